// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding selects, load-use stalls,
// memory-wait freeze, exception drain sequencing and redirect flushes.
module hazard_fwd_unit (
  input  logic [4:0] src,
  input  logic [4:0] ex_dst,
  input  logic [4:0] mem_dst,
  input  logic [4:0] wb_dst,
  input  logic       ex_regwrite,
  input  logic       mem_regwrite,
  input  logic       wb_regwrite,
  output logic [1:0] sel
);
  always_comb begin
    sel = 2'd0;
    if (src != 5'd0) begin
      if (ex_regwrite && ex_dst == src)        sel = 2'd1;
      else if (mem_regwrite && mem_dst == src) sel = 2'd2;
      else if (wb_regwrite && wb_dst == src)   sel = 2'd3;
    end
  end
endmodule

module hazard_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  ex_dst,
  input  logic [4:0]  mem_dst,
  input  logic [4:0]  wb_dst,
  input  logic        ex_regwrite,
  input  logic        mem_regwrite,
  input  logic        wb_regwrite,
  input  logic        ex_memread,
  input  logic        redirect,
  input  logic        exc_req,
  input  logic        dmem_busy,
  output logic [1:0]  ctrl_rs,
  output logic [1:0]  ctrl_rt,
  output logic        if_we,
  output logic        id_we,
  output logic        ex_we,
  output logic        mem_we,
  output logic        wb_we,
  output logic        if_flush,
  output logic        id_flush,
  output logic        ex_flush,
  output logic [1:0]  pc_sel,
  output logic [1:0]  state,
  output logic [15:0] stall_cnt
);
  localparam int NUM_OPS = 2;

  typedef enum logic [1:0] {RUN = 2'd0, MWAIT = 2'd1, EXC = 2'd2} state_e;

  state_e      state_q, state_d;
  logic [1:0]  drain_q, drain_d;
  logic [15:0] stall_q, stall_d;

  logic [NUM_OPS-1:0][4:0] op_src;
  logic [NUM_OPS-1:0][1:0] op_sel;
  logic                    load_use;

  assign op_src = {id_rt, id_rs};

  for (genvar g = 0; g < NUM_OPS; g++) begin : g_fwd
    hazard_fwd_unit u_fwd (
      .src          (op_src[g]),
      .ex_dst       (ex_dst),
      .mem_dst      (mem_dst),
      .wb_dst       (wb_dst),
      .ex_regwrite  (ex_regwrite),
      .mem_regwrite (mem_regwrite),
      .wb_regwrite  (wb_regwrite),
      .sel          (op_sel[g])
    );
  end

  assign load_use = ex_memread && (ex_dst != 5'd0) &&
                    ((ex_dst == id_rs) || (ex_dst == id_rt));

  always_comb begin
    ctrl_rs  = op_sel[0];
    ctrl_rt  = op_sel[1];
    if_we    = 1'b1;
    id_we    = 1'b1;
    ex_we    = 1'b1;
    mem_we   = 1'b1;
    wb_we    = 1'b1;
    if_flush = 1'b0;
    id_flush = 1'b0;
    ex_flush = 1'b0;
    pc_sel   = 2'd0;
    state_d  = state_q;
    drain_d  = drain_q;

    case (state_q)
      RUN: begin
        if (dmem_busy) begin
          {if_we, id_we, ex_we, mem_we, wb_we} = 5'b0;
          state_d = MWAIT;
        end else if (exc_req) begin
          if_we    = 1'b0;
          id_we    = 1'b0;
          id_flush = 1'b1;
          ex_flush = 1'b1;
          drain_d  = 2'd2;
          state_d  = EXC;
        end else if (redirect) begin
          {if_flush, id_flush, ex_flush} = 3'b111;
          pc_sel = 2'd1;
        end else if (load_use) begin
          if_we    = 1'b0;
          id_we    = 1'b0;
          ex_flush = 1'b1;
        end
      end
      MWAIT: begin
        {if_we, id_we, ex_we, mem_we, wb_we} = 5'b0;
        if (!dmem_busy) state_d = RUN;
      end
      EXC: begin
        // A memory stall freezes the drain entirely, including the vector fetch.
        if (dmem_busy) begin
          {if_we, id_we, ex_we, mem_we, wb_we} = 5'b0;
        end else begin
          if_we    = 1'b0;
          id_we    = 1'b0;
          id_flush = 1'b1;
          if (drain_q == 2'd0) begin
            pc_sel  = 2'd2;
            if_we   = 1'b1;
            state_d = RUN;
          end else begin
            drain_d = 2'(drain_q - 2'd1);
          end
        end
      end
      default: state_d = RUN;
    endcase

    if (reset) begin
      {if_we, id_we, ex_we, mem_we, wb_we} = 5'b0;
      {if_flush, id_flush, ex_flush}       = 3'b111;
      pc_sel  = 2'd0;
      ctrl_rs = 2'd0;
      ctrl_rt = 2'd0;
      state_d = RUN;
      drain_d = 2'd0;
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (reset)                             stall_d = 16'd0;
    else if (!id_we && stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
    drain_q <= drain_d;
    stall_q <= stall_d;
  end

  assign state     = state_q;
  assign stall_cnt = stall_q;
endmodule
